// File: rtl/dmem_cam_responder_pkg.sv
// Shared address map, control/status bit positions and decode helpers for the
// data-side responder and its pixel FIFO.
package dmem_pkg;

  localparam logic [31:0] RAM_BASE        = 32'h0000_0000;
  localparam logic [31:0] PIX_DATA_ADDR   = 32'h0001_0000;
  localparam logic [31:0] PIX_STATUS_ADDR = 32'h0001_0004;
  localparam logic [31:0] PIX_CTRL_ADDR   = 32'h0001_0008;
  localparam logic [31:0] CYCLES_ADDR     = 32'h0001_000C;

  localparam int CTRL_POP_BIT     = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_FLUSH_BIT   = 2;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 16;
  localparam int STAT_COUNT_W   = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_PIX_DATA,
    SEL_PIX_STATUS,
    SEL_PIX_CTRL,
    SEL_CYCLES
  } sel_e;

  // Word-granular register match; the byte offset bits never participate.
  function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_cam_responder_pixel_fifo.sv
// Camera pixel FIFO: power-of-two depth, naturally wrapping pointers, sticky
// overflow on dropped pushes, flush that dominates push and pop.
module pixel_fifo
  import dmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  logic                            clear_ovf,
  input  logic [PIX_W-1:0]                din,
  output logic [PIX_W-1:0]                dout,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    drop     = push && full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // A fresh overflow in the same cycle as a clear must survive.
    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_cam_responder.sv
// Data-side responder: word RAM plus memory-mapped camera pixel FIFO, with
// zero-latency loads. Optional CYCLES counter under DMEM_CYCLE_COUNTER_EN.
module dmem_cam_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8,
  parameter     MEM_INIT   = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      WriteAddress,
  input  logic [31:0]      WriteData,
  input  logic             write_enable,
  output logic [31:0]      ReadData,
  input  logic             cam_valid,
  input  logic [PIX_W-1:0] cam_pixel,
  output logic             cam_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  sel_e              sel;
  logic              ctrl_wr;
  logic [PIX_W-1:0]  fifo_dout;
  logic              fifo_empty, fifo_full, fifo_ovf;
  logic [CW-1:0]     fifo_count;
  logic [8:0]        count_ext;
  logic [31:0]       status;
  logic              unused_bits;

  assign ram_idx     = WriteAddress[RAM_AW+1:2];
  assign ctrl_wr     = write_enable && (sel == SEL_PIX_CTRL);
  assign cam_ready   = !fifo_full;
  assign count_ext   = 9'(fifo_count);
  assign unused_bits = ^{WriteAddress[1:0], count_ext[8]};

  always_comb begin
    sel = SEL_NONE;
    if (WriteAddress[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]) sel = SEL_RAM;
    else if (reg_hit(WriteAddress, PIX_DATA_ADDR))          sel = SEL_PIX_DATA;
    else if (reg_hit(WriteAddress, PIX_STATUS_ADDR))        sel = SEL_PIX_STATUS;
    else if (reg_hit(WriteAddress, PIX_CTRL_ADDR))          sel = SEL_PIX_CTRL;
`ifdef DMEM_CYCLE_COUNTER_EN
    else if (reg_hit(WriteAddress, CYCLES_ADDR))            sel = SEL_CYCLES;
`endif
  end

  always_ff @(posedge clk) begin
    if (write_enable && (sel == SEL_RAM)) ram_q[ram_idx] <= WriteData;
  end

  pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PIX_W      (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (cam_valid),
    .pop       (ctrl_wr && WriteData[CTRL_POP_BIT]),
    .flush     (ctrl_wr && WriteData[CTRL_FLUSH_BIT]),
    .clear_ovf (ctrl_wr && WriteData[CTRL_CLR_OVF_BIT]),
    .din       (cam_pixel),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  always_comb begin
    status                                      = '0;
    status[STAT_EMPTY_BIT]                      = fifo_empty;
    status[STAT_FULL_BIT]                       = fifo_full;
    status[STAT_OVF_BIT]                        = fifo_ovf;
    status[STAT_COUNT_LSB +: STAT_COUNT_W]      = count_ext[7:0];
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (write_enable && (sel == SEL_CYCLES) && WriteData[0]) cycles_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end
`endif

  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:        ReadData = ram_q[ram_idx];
      SEL_PIX_DATA:   ReadData = 32'(fifo_dout);
      SEL_PIX_STATUS: ReadData = status;
`ifdef DMEM_CYCLE_COUNTER_EN
      SEL_CYCLES:     ReadData = cycles_q;
`endif
      default:        ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_cam_responder.sv
// Scoreboard bench for dmem_cam_responder: directed steps queue expected load
// data / cam_ready values; a negedge monitor pops and compares.
module tb_dmem_cam_responder;

  localparam logic [31:0] A_DATA   = 32'h0001_0000;
  localparam logic [31:0] A_STATUS = 32'h0001_0004;
  localparam logic [31:0] A_CTRL   = 32'h0001_0008;
  localparam logic [31:0] A_CYCLES = 32'h0001_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteAddress, WriteData, ReadData;
  logic        write_enable, cam_valid, cam_ready;
  logic [7:0]  cam_pixel;
  logic [1:0]  chk_kind;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] expv;
    logic [95:0] tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] actual;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_cam_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (16),
    .PIX_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .write_enable (write_enable),
    .ReadData     (ReadData),
    .cam_valid    (cam_valid),
    .cam_pixel    (cam_pixel),
    .cam_ready    (cam_ready)
  );

  always @(negedge clk) begin
    if (chk_kind != 2'd0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: monitor saw check kind %0d with no expected entry", chk_kind);
      end else begin
        e = sb.pop_front();
        actual = (e.kind == 2'd2) ? {31'b0, cam_ready} : ReadData;
        if (actual !== e.expv) begin
          failures++;
          $display("FAIL %s: got %h want %h", e.tag, actual, e.expv);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic cv, input logic [7:0] pix,
                      input logic [1:0] kind, input logic [31:0] expv, input logic [95:0] tag);
    @(posedge clk);
    #1;
    reset        = rst;
    write_enable = we;
    WriteAddress = addr;
    WriteData    = wd;
    cam_valid    = cv;
    cam_pixel    = pix;
    chk_kind     = kind;
    if (kind != 2'd0) sb.push_back('{kind, expv, tag});
  endtask

  task automatic idle();                     step(1, 0, 32'h0, 32'h0, 0, 8'h0, 0, 32'h0, "idle"); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(1, 1, a, d, 0, 8'h0, 0, 32'h0, "wr"); endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] x, input logic [95:0] t); step(1, 0, a, 32'h0, 0, 8'h0, 1, x, t); endtask
  task automatic px(input logic [7:0] p);    step(1, 0, 32'h0, 32'h0, 1, p, 0, 32'h0, "px"); endtask
  task automatic rdy(input logic x, input logic [95:0] t); step(1, 0, 32'h0, 32'h0, 0, 8'h0, 2, {31'b0, x}, t); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; write_enable = 1'b0; WriteAddress = '0; WriteData = '0;
    cam_valid = 1'b0; cam_pixel = '0; chk_kind = 2'd0;

    // reset state
    step(0, 0, A_STATUS, 0, 0, 0, 1, 32'h0000_0001, "rst_status");
    step(0, 0, 32'h0, 0, 0, 0, 2, 32'h1, "rst_ready");

    // RAM and decode
    step(1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0, "wr40");
    rd(32'h40, 32'hDEAD_BEEF, "ram_40");
    rd(32'h43, 32'hDEAD_BEEF, "ram_43");
    rd(32'h0002_0000, 32'h0, "unmapped");
    wr(32'h0FFC, 32'h1234_5678);
    rd(32'h0FFC, 32'h1234_5678, "ram_top");
    wr(32'h1040, 32'hCAFE_F00D);
    rd(32'h40, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h1040, 32'h0, "above_ram");
    wr(32'h0002_0000, 32'h5555_5555);
    rd(32'h0002_0000, 32'h0, "unmap_wr");
    rd(A_CTRL, 32'h0, "ctrl_rd0");
    rd(A_DATA, 32'h0, "data_empty");

    // basic push / pop
    px(8'h11); px(8'h22); px(8'h33);
    rd(A_STATUS, 32'h0003_0000, "stat3");
    rd(A_DATA, 32'h11, "head11");
    wr(A_CTRL, 32'h1);
    rd(A_DATA, 32'h22, "head22");
    rd(A_STATUS, 32'h0002_0000, "stat2");

    // fill past full
    wr(A_CTRL, 32'h4);
    rd(A_STATUS, 32'h0000_0001, "flushed");
    for (int i = 0; i < 17; i++) px(8'hA0 + 8'(i));
    rdy(1'b0, "full_ready");
    rd(A_STATUS, 32'h0010_0006, "stat_full");
    rd(A_DATA, 32'hA0, "head_full");
    wr(A_CTRL, 32'h2);
    rd(A_STATUS, 32'h0010_0002, "ovf_clr");

    // full with pop and push together: pop only, push dropped
    step(1, 1, A_CTRL, 32'h1, 1, 8'hEE, 0, 0, "popfull");
    rd(A_STATUS, 32'h000F_0004, "stat_pf");
    rd(A_DATA, 32'hA1, "head_pf");
    rdy(1'b1, "ready_pf");

    // not full / not empty: pop and push, count unchanged
    step(1, 1, A_CTRL, 32'h1, 1, 8'hC1, 0, 0, "poppush");
    rd(A_STATUS, 32'h000F_0004, "stat_pp");
    px(8'hC2);
    rd(A_STATUS, 32'h0010_0006, "refull");

    // clear and new overflow same cycle: set wins
    step(1, 1, A_CTRL, 32'h2, 1, 8'hDD, 0, 0, "clrset");
    rd(A_STATUS, 32'h0010_0006, "set_wins");

    // drain in order across the pointer wrap
    for (int i = 0; i < 14; i++) begin
      rd(A_DATA, 32'hA2 + 32'(i), "drain");
      wr(A_CTRL, 32'h1);
    end
    rd(A_DATA, 32'hC1, "drain_c1");
    wr(A_CTRL, 32'h1);
    rd(A_DATA, 32'hC2, "drain_c2");
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h0000_0005, "drained");
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h0000_0005, "pop_empty");
    wr(A_CTRL, 32'h2);
    rd(A_STATUS, 32'h0000_0001, "ovf_clr2");

    // empty with pop and push: push only
    step(1, 1, A_CTRL, 32'h1, 1, 8'h55, 0, 0, "pushempty");
    rd(A_STATUS, 32'h0001_0000, "stat_pe");
    rd(A_DATA, 32'h55, "head_pe");

    // flush beats push, dropped push does not set overflow
    step(1, 1, A_CTRL, 32'h4, 1, 8'h66, 0, 0, "flushpush");
    rd(A_STATUS, 32'h0000_0001, "flush_cv");

    // reset mid-stream
    for (int i = 0; i < 5; i++) px(8'h71 + 8'(i));
    rd(A_STATUS, 32'h0005_0000, "stat5");
    step(0, 0, A_STATUS, 0, 0, 0, 1, 32'h0000_0001, "midrst_stat");
    step(0, 0, 32'h0, 0, 0, 0, 2, 32'h1, "midrst_rdy");
    step(0, 0, 32'h40, 0, 0, 0, 1, 32'hDEAD_BEEF, "ram_kept");
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, "release");
    rd(A_DATA, 32'h0, "post_rst");
    for (int i = 0; i < 8; i++) idle();
`ifdef DMEM_CYCLE_COUNTER_EN
    rd(A_CYCLES, 32'd10, "cycles10");
`else
    rd(A_CYCLES, 32'd0, "cycles_off");
`endif

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
